// File: rtl/period_capture_pkg.sv
// Shared types and default sizing for the period_capture block.
package period_capture_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  // One queued interval at the default width; the top builds the same
  // layout at its own WIDTH.
  typedef struct packed {
    logic                     is_long;
    logic [DEFAULT_WIDTH-1:0] delta;
  } entry_t;

endpackage

// File: rtl/period_capture_if.sv
// Valid/ready stream carrying captured intervals out of period_capture.
interface period_capture_if
  import period_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_delta;
  logic             out_long;

  modport master (
    output out_valid,
    output out_delta,
    output out_long,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_delta,
    input  out_long,
    output out_ready
  );

endinterface

// File: rtl/period_capture_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr[AW-1:0]];

  // Storage write; contents need no reset since empty gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/period_capture.sv
// Measures the interval between rising edges of event_in using an upstream
// free-running counter, queues each interval and streams it out.
module period_capture
  import period_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              event_in,
  input  logic              clr_ovf,
  period_capture_if.master  out,
  output logic              overflow
);

  typedef struct packed {
    logic             is_long;
    logic [WIDTH-1:0] delta;
  } entry_w_t;

  localparam logic [WIDTH:0] AGE_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] AGE_ONE = (WIDTH+1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic             event_q;
  logic             rise;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] last_count;
  logic [WIDTH-1:0] delta;
  logic [WIDTH:0]   age;
  entry_w_t         push_entry;
  entry_w_t         head_entry;

  // event_q resets high so a level already asserted through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= 1'b1;
    end else begin
      event_q <= event_in;
    end
  end

  assign rise = event_in & ~event_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The first edge only arms; later edges capture and push an interval.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          capture   = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          capture = 1'b1;
          push    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reference count and saturating age since the last captured edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_count <= '0;
      age        <= '0;
    end else if (capture) begin
      last_count <= count_in;
      age        <= '0;
    end else if (state == ARMED && age != AGE_MAX) begin
      age <= age + AGE_ONE;
    end
  end

  assign delta = count_in + ~last_count + WIDTH'(1);

  // Assemble the entry queued on each measuring edge.
  always_comb begin
    push_entry         = '0;
    push_entry.is_long = (age == AGE_MAX);
    push_entry.delta   = delta;
  end

  assign pop  = out.out_valid & out.out_ready;
  assign drop = push & full & ~pop;

  // Sticky overflow; a drop in the same cycle as clr_ovf leaves it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head_entry)
  );

  assign out.out_valid = ~empty;
  assign out.out_delta = empty ? '0   : head_entry.delta;
  assign out.out_long  = empty ? 1'b0 : head_entry.is_long;

endmodule

// File: tb/tb_period_capture.sv
// Directed bench for period_capture with hand-computed interval values.
module tb_period_capture;

  logic       clk;
  logic       reset;
  logic [7:0] count_in;
  logic       event_in;
  logic       clr_ovf;
  logic       overflow;
  int         checks;
  int         errors;

  period_capture_if #(.WIDTH(8)) bus ();

  period_capture #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .event_in (event_in),
    .clr_ovf  (clr_ovf),
    .out      (bus.master),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge of event_in sampled with count_in = v, then event low.
  task automatic pulse(input logic [7:0] v);
    count_in = v;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    step();
  endtask

  // Check the head entry, then pop it.
  task automatic expect_pop(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_delta"}, {24'd0, bus.out_delta}, {24'd0, d});
    check({tag, "_long"},  {31'd0, bus.out_long},  {31'd0, l});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    count_in      = 8'd0;
    event_in      = 1'b0;
    clr_ovf       = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    check("rst_delta",    {24'd0, bus.out_delta}, 32'd0);
    check("rst_long",     {31'd0, bus.out_long},  32'd0);
    check("rst_overflow", {31'd0, overflow},      32'd0);
    reset = 1'b0;
    step();

    // Arm at 10, measure at 35: one-cycle latency to out_valid.
    count_in = 8'd10;
    event_in = 1'b1;
    step();
    check("arm_novalid", {31'd0, bus.out_valid}, 32'd0);
    event_in = 1'b0;
    step();
    check("arm_novalid2", {31'd0, bus.out_valid}, 32'd0);
    count_in = 8'd35;
    event_in = 1'b1;
    step();
    check("meas_valid", {31'd0, bus.out_valid}, 32'd1);
    check("meas_delta", {24'd0, bus.out_delta}, 32'd25);
    check("meas_long",  {31'd0, bus.out_long},  32'd0);
    event_in = 1'b0;
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("meas_empty", {31'd0, bus.out_valid}, 32'd0);

    // Wrap-around: 35 -> 250 -> 4.
    pulse(8'd250);
    expect_pop("wrap_a", 8'd215, 1'b0);
    pulse(8'd4);
    expect_pop("wrap_b", 8'd10, 1'b0);

    // Long interval: edges 300 cycles apart with an incrementing counter.
    count_in = 8'd100;
    event_in = 1'b1;
    step();
    check("long_pre_delta", {24'd0, bus.out_delta}, 32'd96);
    event_in      = 1'b0;
    bus.out_ready = 1'b1;
    count_in      = 8'd101;
    step();
    bus.out_ready = 1'b0;
    for (int i = 2; i < 300; i++) begin
      count_in = 8'(100 + i);
      step();
    end
    count_in = 8'd144;
    event_in = 1'b1;
    step();
    event_in = 1'b0;
    step();
    expect_pop("long", 8'd44, 1'b1);

    // Overrun: six edges with no consumer; two are dropped.
    pulse(8'd150);
    pulse(8'd160);
    pulse(8'd175);
    pulse(8'd180);
    check("ovr_at4", {31'd0, overflow}, 32'd0);
    pulse(8'd200);
    check("ovr_at5", {31'd0, overflow}, 32'd1);
    pulse(8'd210);
    check("ovr_at6", {31'd0, overflow}, 32'd1);
    step();
    check("ovr_hold_delta", {24'd0, bus.out_delta}, 32'd6);
    expect_pop("ovr_d0", 8'd6,  1'b0);
    expect_pop("ovr_d1", 8'd10, 1'b0);
    expect_pop("ovr_d2", 8'd15, 1'b0);
    expect_pop("ovr_d3", 8'd5,  1'b0);
    check("ovr_drained", {31'd0, bus.out_valid}, 32'd0);
    check("ovr_sticky",  {31'd0, overflow},      32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovr_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop on the same edge as a push.
    pulse(8'd215);
    pulse(8'd225);
    pulse(8'd240);
    pulse(8'd250);
    count_in      = 8'd0;
    event_in      = 1'b1;
    bus.out_ready = 1'b1;
    step();
    event_in      = 1'b0;
    bus.out_ready = 1'b0;
    check("fullpop_ovf",  {31'd0, overflow},      32'd0);
    check("fullpop_head", {24'd0, bus.out_delta}, 32'd10);
    step();

    // Dropping push coincident with clr_ovf: set wins.
    count_in = 8'd20;
    event_in = 1'b1;
    clr_ovf  = 1'b1;
    step();
    event_in = 1'b0;
    clr_ovf  = 1'b0;
    check("setwins_ovf", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("setwins_clr", {31'd0, overflow}, 32'd0);
    expect_pop("fullpop_d0", 8'd10, 1'b0);
    expect_pop("fullpop_d1", 8'd15, 1'b0);
    expect_pop("fullpop_d2", 8'd10, 1'b0);
    expect_pop("fullpop_d3", 8'd6,  1'b0);
    check("fullpop_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-operation with event_in held high.
    pulse(8'd30);
    pulse(8'd50);
    check("rmid_valid", {31'd0, bus.out_valid}, 32'd1);
    count_in = 8'd60;
    event_in = 1'b1;
    reset    = 1'b1;
    step();
    check("rmid_in_rst", {31'd0, bus.out_valid}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("rmid_after",     {31'd0, bus.out_valid}, 32'd0);
    check("rmid_after_ovf", {31'd0, overflow},      32'd0);
    event_in = 1'b0;
    step();
    count_in = 8'd70;
    event_in = 1'b1;
    step();
    check("rmid_rearm", {31'd0, bus.out_valid}, 32'd0);
    event_in = 1'b0;
    step();
    check("rmid_rearm2", {31'd0, bus.out_valid}, 32'd0);
    pulse(8'd75);
    expect_pop("rmid_first", 8'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
